// File: rtl/band_mixer_pkg.sv
// Shared definitions for the band mixer: mode encodings, FSM states and
// the arithmetic helpers used by the top level and the gain bank.
// No ports; imported with band_mixer_pkg::*.
package band_mixer_pkg;

    // Mode encodings. 2'b11 is decoded as bypass by the default case arm.
    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_MIX    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    // Unity gain for a gain word with 'frac' fractional bits.
    // The caller truncates the result to its gain width.
    function automatic logic [31:0] unity_gain(input int frac);
        return 32'd1 << frac;
    endfunction

    // Clamp v to the signed range of a w-bit word.
    // The result is returned 64 bits wide; a clip is detected by the caller
    // comparing the result with the input.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/band_mixer_gain_bank.sv
// Gain register file: NBANDS signed gains with one write port, reset to unity.
// Ports: clk_i/rst_i, write port (we_i, addr_i, data_i), shadow_en_i copies the
// live gains into a shadow set, shadow_o is that set packed (band i at [i*GainW +: GainW]).
module band_mixer_gain_bank
    import band_mixer_pkg::*;
#(
    parameter int NBANDS   = 3,
    parameter int GainW    = 8,
    parameter int GainFrac = 6,
    parameter int AddrW    = $clog2(NBANDS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [AddrW-1:0]          addr_i,
    input  logic [GainW-1:0]          data_i,
    input  logic                      shadow_en_i,
    output logic [NBANDS*GainW-1:0]   shadow_o
);

    localparam logic [GainW-1:0] UNITY = GainW'(unity_gain(GainFrac));

    logic [GainW-1:0] gain_q   [NBANDS];
    logic [GainW-1:0] shadow_q [NBANDS];

    // The shadow copy takes the pre-edge gains, so a write landing on the
    // same edge as the shadow latch only affects the following sample.
    // Addresses >= NBANDS match no entry and are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBANDS; i++) begin
                gain_q[i]   <= UNITY;
                shadow_q[i] <= UNITY;
            end
        end else begin
            for (int i = 0; i < NBANDS; i++) begin
                if (we_i && (addr_i == AddrW'(i))) begin
                    gain_q[i] <= data_i;
                end
                if (shadow_en_i) begin
                    shadow_q[i] <= gain_q[i];
                end
            end
        end
    end

    always_comb begin
        shadow_o = '0;
        for (int i = 0; i < NBANDS; i++) begin
            shadow_o[i*GainW +: GainW] = shadow_q[i];
        end
    end

endmodule

// File: rtl/band_mixer.sv
// Band mixer: weights NBANDS filter outputs with programmable gains through one
// shared multiplier (one band per clock), saturates, and drives yk with a valid pulse.
// Ports: clock/reset, enable strobe, mode/seleccion, uk, packed yk_bands, gain write
// port; outputs yk, yk_valid, busy, sticky overrun, sat_flag.
// Build option: BAND_MIXER_OFFSET_EN adds OFFSET (mod 2^Width) after saturation.
module band_mixer
    import band_mixer_pkg::*;
#(
    parameter int              Width     = 22,
    parameter int              Presicion = 14,
    parameter int              NBANDS    = 3,
    parameter int              GainW     = 8,
    parameter int              GainFrac  = 6,
    parameter logic [Width-1:0] OFFSET   = 'h6000,
    localparam int             SelW      = $clog2(NBANDS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [SelW-1:0]           seleccion,
    input  logic [Width-1:0]          uk,
    input  logic [NBANDS*Width-1:0]   yk_bands,
    input  logic                      gain_we,
    input  logic [SelW-1:0]           gain_addr,
    input  logic [GainW-1:0]          gain_data,
    output logic [Width-1:0]          yk,
    output logic                      yk_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic                      sat_flag
);

    localparam int PW = Width + GainW;          // product width
    localparam int AW = Width + GainW + SelW;   // accumulator width, no internal overflow

    state_t                   state_q, state_d;
    logic [SelW-1:0]          idx_q, idx_d;
    logic signed [Width-1:0]  uk_q, uk_d;
    logic [NBANDS*Width-1:0]  bands_q, bands_d;
    logic [1:0]               mode_q, mode_d;
    logic [SelW-1:0]          sel_q, sel_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [Width-1:0]         yk_q, yk_d;
    logic                     vld_q, vld_d;
    logic                     sat_q, sat_d;
    logic                     ovr_q, ovr_d;

    logic                     shadow_en;
    logic [NBANDS*GainW-1:0]  shadow_gains;

    logic signed [Width-1:0]  band;
    logic signed [GainW-1:0]  gain;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;
    logic signed [AW-1:0]     term;
    logic signed [63:0]       acc_ext;
    logic signed [63:0]       sat_full;
    logic [Width-1:0]         sat_val;
    logic                     clipped;

    band_mixer_gain_bank #(
        .NBANDS   (NBANDS),
        .GainW    (GainW),
        .GainFrac (GainFrac),
        .AddrW    (SelW)
    ) u_gain_bank (
        .clk_i       (clock),
        .rst_i       (reset),
        .we_i        (gain_we),
        .addr_i      (gain_addr),
        .data_i      (gain_data),
        .shadow_en_i (shadow_en),
        .shadow_o    (shadow_gains)
    );

    // Per-band contribution for the current idx; only consumed in ACC.
    always_comb begin
        band   = bands_q[idx_q*Width +: Width];
        gain   = shadow_gains[idx_q*GainW +: GainW];
        prod   = PW'(band) * PW'(gain);
        scaled = prod >>> GainFrac;
        case (mode_q)
            MODE_MIX:    term = AW'(scaled);
            MODE_SINGLE: term = (idx_q == sel_q) ? AW'(band) : '0;
            default:     term = (idx_q == '0) ? AW'(uk_q) : '0;
        endcase
    end

    // Saturation of the finished sum.
    always_comb begin
        acc_ext  = 64'(acc_q);
        sat_full = sat_clamp(acc_ext, Width);
        sat_val  = sat_full[Width-1:0];
        clipped  = (sat_full != acc_ext);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        uk_d      = uk_q;
        bands_d   = bands_q;
        mode_d    = mode_q;
        sel_d     = sel_q;
        acc_d     = acc_q;
        yk_d      = yk_q;
        vld_d     = 1'b0;
        sat_d     = 1'b0;
        ovr_d     = ovr_q;
        shadow_en = 1'b0;

        // A strobe outside IDLE is dropped but remembered.
        if (enable && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    uk_d      = uk;
                    bands_d   = yk_bands;
                    mode_d    = mode;
                    sel_d     = seleccion;
                    acc_d     = '0;
                    idx_d     = '0;
                    shadow_en = 1'b1;
                    state_d   = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d = acc_q + term;
                if (idx_q == SelW'(NBANDS - 1)) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + SelW'(1);
                end
            end
            ST_SAT: begin
`ifdef BAND_MIXER_OFFSET_EN
                yk_d = sat_val + OFFSET;
`else
                yk_d = sat_val;
`endif
                sat_d   = clipped;
                vld_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            uk_q    <= '0;
            bands_q <= '0;
            mode_q  <= MODE_BYPASS;
            sel_q   <= '0;
            acc_q   <= '0;
            yk_q    <= '0;
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            uk_q    <= uk_d;
            bands_q <= bands_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            yk_q    <= yk_d;
            vld_q   <= vld_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign yk       = yk_q;
    assign yk_valid = vld_q;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = ovr_q;
    assign sat_flag = sat_q;

endmodule
